// File: rtl/md_unit_pkg.sv
// md_unit_pkg -- shared constants for the multiply/divide unit.
//   MDOp operation codes, FSM state encoding, RdSel encoding, and op-class
//   helpers used by both the FSM acceptance logic and the Stall decode.
// Optional feature: MD_UNIT_MACC_EN adds MADD/MADDU/MSUB/MSUBU to the
// multiply class; without it codes 7-10 decode as NOP.
package md_unit_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam logic RDSEL_LO = 1'b0;
  localparam logic RDSEL_HI = 1'b1;

  // Ops that occupy the multiplier for MUL_CYCLES.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MD_UNIT_MACC_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/md_div.sv
// md_div -- combinational signed/unsigned divider.
//   a, b : dividend / divisor
//   sgn  : 1 = two's-complement divide, 0 = unsigned
//   quo  : quotient, truncated toward zero
//   rem  : remainder, carries the dividend's sign
// Divide by zero gives quo = all ones, rem = a. The signed overflow case
// (most-negative / -1) gives quo = most-negative, rem = 0.
module md_div #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // Keep the core divide defined for b == 0; that result is overridden below.
    q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else if (sgn && a == MOST_NEG && b == '1) begin
      quo = MOST_NEG;
      rem = '0;
    end else begin
      quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem = a_neg ? -r_mag : r_mag;
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit -- MIPS-style HI/LO multiply/divide unit.
//   clk, reset    : clock, synchronous active-low reset
//   D1, D2        : rs / rt operands, latched at acceptance
//   MDOp          : operation code (md_unit_pkg OP_*)
//   Flush         : cancel in-flight op, block acceptance this cycle
//   RdSel         : 0 = LO, 1 = HI onto MD_Out
//   MD_Out        : selected HI/LO (combinational)
//   Busy          : multi-cycle op in flight
//   Stall         : pipeline hold (Busy, or a multi-cycle op waiting in IDLE)
// Optional feature: define MD_UNIT_MACC_EN for MADD/MADDU/MSUB/MSUBU.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [3:0]       MDOp,
  input  logic             Flush,
  input  logic             RdSel,
  output logic [WIDTH-1:0] MD_Out,
  output logic             Busy,
  output logic             Stall
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo, a_q, b_q;
  logic [3:0]         op_q;
  logic               busy_q;

  logic               sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  logic [WIDTH-1:0]   quo, rem;

  // Extending both operands to 2*WIDTH (sign or zero per op) makes the low
  // 2*WIDTH bits of a plain multiply the correct signed/unsigned product.
  always_comb begin
    sgn     = is_signed_op(op_q);
    ext_a   = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ext_a * ext_b;
    mul_res = prod;
`ifdef MD_UNIT_MACC_EN
    // HI/LO cannot change while busy, so accumulating at completion equals
    // accumulating against the values present at acceptance.
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
      default:           mul_res = prod;
    endcase
`endif
  end

  md_div #(.WIDTH(WIDTH)) u_div (
    .a   (a_q),
    .b   (b_q),
    .sgn (sgn),
    .quo (quo),
    .rem (rem)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_NOP;
      busy_q <= 1'b0;
    end else if (Flush) begin
      // Cancels any op, including the one finishing this cycle.
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mul_op(MDOp) || is_div_op(MDOp)) begin
            a_q    <= D1;
            b_q    <= D2;
            op_q   <= MDOp;
            busy_q <= 1'b1;
            state  <= is_div_op(MDOp) ? ST_DIV : ST_MUL;
            cnt    <= is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          end else if (MDOp == OP_MTHI) begin
            hi <= D1;
          end else if (MDOp == OP_MTLO) begin
            lo <= D1;
          end
        end
        default: begin
          // cnt == 1 marks the last busy cycle; its closing edge commits.
          if (cnt == CNT_W'(1)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            if (state == ST_DIV) begin
              hi <= rem;
              lo <= quo;
            end else begin
              {hi, lo} <= mul_res;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Stall  = busy_q | ((state == ST_IDLE) & (is_mul_op(MDOp) | is_div_op(MDOp)));
  assign MD_Out = (RdSel == RDSEL_HI) ? hi : lo;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameters SHALL be WIDTH 32 (operand/HI/LO width), MUL_CYCLES 5 (multiply latency, >=1), DIV_CYCLES 10 (divide latency, >=1).
REQ-002 Ports SHALL be: clk in 1 (single clock); reset in 1 (synchronous, active-low).
REQ-003 Ports SHALL be: D1 in WIDTH (rs operand); D2 in WIDTH (rt operand); MDOp in 4 (operation code); Flush in 1 (cancel in-flight operation).
REQ-004 Ports SHALL be: RdSel in 1 (0=LO, 1=HI); MD_Out out WIDTH (selected HI/LO); Busy out 1 (operation in flight); Stall out 1 (pipeline hold request).
REQ-005 MDOp codes SHALL be 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as NOP.

Function
REQ-006 FSM SHALL have states IDLE, MUL, DIV; a down-counter of ceil(log2(max latency+1)) bits tracks remaining cycles.
REQ-007 An op SHALL be accepted only in IDLE with Flush low; ops presented while Busy high SHALL be ignored (caller holds them via Stall).
REQ-008 Accepting MULT/MULTU/MADD*/MSUB* SHALL latch operands, enter MUL, load counter with MUL_CYCLES; DIV/DIVU enter DIV with DIV_CYCLES.
REQ-009 Busy SHALL be high from the cycle after acceptance for exactly the op's latency cycles; HI/LO SHALL update on the clock edge ending the last busy cycle; FSM returns to IDLE at that edge.
REQ-010 Stall SHALL equal Busy OR (IDLE and MDOp in {1..4,7..10}), combinationally.
REQ-011 MTHI/MTLO SHALL write D1 into HI/LO at the accepting edge, without entering MUL/DIV and without asserting Busy.
REQ-012 MULT/MADD/MSUB SHALL use signed 2*WIDTH products; MULTU/MADDU/MSUBU unsigned; {HI,LO} = product, {HI,LO}+product, {HI,LO}-product resp., modulo 2^(2*WIDTH).
REQ-013 DIV SHALL give LO=quotient truncated toward zero, HI=remainder with dividend's sign; DIVU unsigned.
REQ-014 Divide by zero SHALL give LO=all ones, HI=D1 (signed and unsigned).
REQ-015 Signed overflow (D1=most-negative, D2=-1) SHALL give LO=most-negative, HI=0.
REQ-016 MD_Out SHALL be combinational from current HI/LO per RdSel; during Busy it SHALL show pre-operation values.
REQ-017 Flush high SHALL return FSM to IDLE at the next edge, leave HI/LO unchanged, and block acceptance of any op that cycle, including MTHI/MTLO.
REQ-018 Flush coinciding with the final busy cycle SHALL take precedence: no HI/LO update.
REQ-019 Results SHALL be computed from operands latched at acceptance; D1/D2 changes during Busy SHALL have no effect.

Reset
REQ-020 reset low at a clk edge SHALL set HI=0, LO=0, FSM=IDLE, counter=0, latched operands=0; Busy=0 and Stall follows REQ-010 from the next cycle.
REQ-021 reset SHALL override Flush and any in-flight operation; no HI/LO write that edge.

Configuration
REQ-022 Macro MD_UNIT_MACC_EN defined SHALL enable MADD/MADDU/MSUB/MSUBU per REQ-012.
REQ-023 Without MD_UNIT_MACC_EN, codes 7-10 SHALL be NOP (no Stall, no Busy, HI/LO unchanged) and accumulate datapath SHALL not be synthesised.

Structure
REQ-024 A shared package SHALL hold MDOp code constants, FSM state encoding, and the RdSel encoding.
REQ-025 Division SHALL live in one sub-module md_div (combinational signed/unsigned quotient/remainder with REQ-014/015 corner handling); md_unit owns FSM, counter, HI/LO.

Verification
REQ-026 MULT D1=0xFFFFFFFE, D2=3 -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-027 DIV D1=-7, D2=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV D1=0x80000000, D2=-1 -> LO=0x80000000, HI=0; DIVU D1=5, D2=0 -> LO=0xFFFFFFFF, HI=5.
REQ-028 DIV accepted, Flush asserted at busy cycle 4 -> IDLE next cycle, HI/LO keep prior values; Flush at last busy cycle -> no update.
REQ-029 MTHI 0x12345678 then MTLO 0x9 back-to-back -> no Busy, RdSel=1 gives 0x12345678, RdSel=0 gives 0x9; MULT held while Busy -> executes once, after completion.
REQ-030 With MD_UNIT_MACC_EN: HI/LO=0/10, MADD D1=3, D2=4 -> LO=22; MSUBU D1=30, D2=1 -> {HI,LO}=0xFFFFFFFF_FFFFFFF8; without macro MADD -> Stall=0, HI/LO unchanged.
REQ-031 reset low during MUL busy cycle 2 -> next cycle Busy=0, HI=LO=0, MD_Out=0.
